// File: rtl/mnist_pkg.sv
// mnist_pkg: constants, the pooling FSM state type and a signed-max helper
// shared by the maxpool1 files.
//   DATA_W      - signed feature-map sample width
//   CONV1_CH    - number of conv1 output channels
//   CONV1_OUT_W - conv1 output map width (= height)
//   POOL1_OUT_W - pooled map width (= height)
package mnist_pkg;

  localparam int unsigned DATA_W      = 12;
  localparam int unsigned CONV1_CH    = 3;
  localparam int unsigned CONV1_OUT_W = 24;
  localparam int unsigned POOL1_OUT_W = 12;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWb,
    StDone
  } pool_state_e;

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool1_addr_gen.sv
// maxpool1_addr_gen: channel / pooled-row / pooled-column / window-element
// counters for the 2x2 stride-2 pooling pass, plus the address arithmetic.
// Ports:
//   i_clk, i_rst_n   - clock, synchronous active-low reset
//   i_clear          - zero all counters (pass start)
//   i_adv_k          - step the window element index k (0..3, wraps)
//   i_adv_win        - step to the next window (c fastest, then r, then ch)
//   o_k              - current window element index
//   o_raddr          - conv1 RAM address of element k of the current window
//   o_waddr          - pool1 RAM address of the current window
//   o_last_window    - current window is the final one of the pass
module maxpool1_addr_gen
  import mnist_pkg::*;
#(
  parameter int unsigned CH      = CONV1_CH,
  parameter int unsigned IN_W    = CONV1_OUT_W,
  parameter int unsigned RADDR_W = 11,
  parameter int unsigned WADDR_W = 9
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_adv_k,
  input  logic               i_adv_win,
  output logic [1:0]         o_k,
  output logic [RADDR_W-1:0] o_raddr,
  output logic [WADDR_W-1:0] o_waddr,
  output logic               o_last_window
);

  localparam int unsigned OutW = IN_W / 2;
  localparam int unsigned RcW  = (OutW > 1) ? $clog2(OutW) : 1;
  localparam int unsigned ChW  = (CH > 1) ? $clog2(CH) : 1;

  logic [ChW-1:0] r_ch;
  logic [RcW-1:0] r_row;
  logic [RcW-1:0] r_col;
  logic [1:0]     r_k;

  logic w_col_last;
  logic w_row_last;
  logic w_ch_last;

  assign w_col_last = (r_col == RcW'(OutW - 1));
  assign w_row_last = (r_row == RcW'(OutW - 1));
  assign w_ch_last  = (r_ch == ChW'(CH - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_ch  <= '0;
      r_row <= '0;
      r_col <= '0;
      r_k   <= '0;
    end else begin
      if (i_adv_k) begin
        r_k <= r_k + 2'd1;
      end
      if (i_adv_win) begin
        if (!w_col_last) begin
          r_col <= r_col + 1'b1;
        end else begin
          r_col <= '0;
          if (!w_row_last) begin
            r_row <= r_row + 1'b1;
          end else begin
            r_row <= '0;
            r_ch  <= w_ch_last ? '0 : r_ch + 1'b1;
          end
        end
      end
    end
  end

  // {row, k[1]} = 2r + dy and {col, k[0]} = 2c + dx: element k of the window.
  assign o_raddr = RADDR_W'(r_ch) * RADDR_W'(IN_W * IN_W)
                 + RADDR_W'({r_row, r_k[1]}) * RADDR_W'(IN_W)
                 + RADDR_W'({r_col, r_k[0]});

  assign o_waddr = WADDR_W'(r_ch) * WADDR_W'(OutW * OutW)
                 + WADDR_W'(r_row) * WADDR_W'(OutW)
                 + WADDR_W'(r_col);

  assign o_k           = r_k;
  assign o_last_window = w_ch_last & w_row_last & w_col_last;

endmodule

// File: rtl/maxpool1.sv
// maxpool1: 2x2 stride-2 signed max-pooling of the conv1 feature maps.
// A pass starts on the falling edge of i_upstream_busy while idle, reads each
// window (4 reads), and writes one pooled value per window (5-cycle period).
// Build option: define MAXPOOL1_RELU_EN to clamp negative pooled values to 0.
// Ports:
//   i_clk, i_rst_n   - clock, synchronous active-low reset
//   i_upstream_busy  - conv1 busy flag; its falling edge starts a pass
//   i_data_in        - conv1 RAM read data, valid one cycle after o_ren
//   o_raddr, o_ren   - conv1 RAM read port
//   o_waddr, o_wen   - pool1 RAM write port (o_wen is a one-cycle pulse)
//   o_data_out       - pooled value written with o_wen
//   o_busy           - high while a pass is in progress
module maxpool1
  import mnist_pkg::*;
#(
  parameter int unsigned CH      = CONV1_CH,
  parameter int unsigned IN_W    = CONV1_OUT_W,
  parameter int unsigned DATA_W  = mnist_pkg::DATA_W,
  parameter int unsigned RADDR_W = 11,
  parameter int unsigned WADDR_W = 9
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_upstream_busy,
  input  logic [DATA_W-1:0]  i_data_in,
  output logic [RADDR_W-1:0] o_raddr,
  output logic               o_ren,
  output logic [WADDR_W-1:0] o_waddr,
  output logic               o_wen,
  output logic [DATA_W-1:0]  o_data_out,
  output logic               o_busy
);

  pool_state_e r_state;
  pool_state_e w_state_n;
  logic        r_ub_prev;

  logic               w_start;
  logic               w_clear;
  logic               w_adv_k;
  logic               w_adv_win;
  logic [1:0]         w_k;
  logic               w_last_window;
  logic [RADDR_W-1:0] w_raddr;
  logic [WADDR_W-1:0] w_waddr;

  logic signed [DATA_W-1:0] w_din;
  logic signed [DATA_W-1:0] w_max_fin;
  logic signed [DATA_W-1:0] w_pooled;
  logic signed [DATA_W-1:0] r_max;
  logic                     r_wen;
  logic [WADDR_W-1:0]       r_waddr;
  logic [DATA_W-1:0]        r_dout;

  maxpool1_addr_gen #(
    .CH      (CH),
    .IN_W    (IN_W),
    .RADDR_W (RADDR_W),
    .WADDR_W (WADDR_W)
  ) u_addr_gen (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_clear       (w_clear),
    .i_adv_k       (w_adv_k),
    .i_adv_win     (w_adv_win),
    .o_k           (w_k),
    .o_raddr       (w_raddr),
    .o_waddr       (w_waddr),
    .o_last_window (w_last_window)
  );

  assign w_start = (r_state == StIdle) && r_ub_prev && !i_upstream_busy;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_ub_prev <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_ub_prev <= i_upstream_busy;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_clear   = 1'b0;
    w_adv_k   = 1'b0;
    w_adv_win = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_n = StRd;
          w_clear   = 1'b1;
        end
      end
      StRd: begin
        w_adv_k = 1'b1;
        if (w_k == 2'd3) begin
          w_state_n = StWb;
        end
      end
      StWb: begin
        w_adv_win = 1'b1;
        w_state_n = w_last_window ? StDone : StRd;
      end
      StDone:  w_state_n = StIdle;
      default: w_state_n = StIdle;
    endcase
  end

  // Read data lags the address by one cycle: in RD with k=n the bus carries
  // element n-1, and in WB it carries element 3.
  assign w_din     = signed'(i_data_in);
  assign w_max_fin = smax(r_max, w_din);

`ifdef MAXPOOL1_RELU_EN
  assign w_pooled = w_max_fin[DATA_W-1] ? '0 : w_max_fin;
`else
  assign w_pooled = w_max_fin;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_max   <= '0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_dout  <= '0;
    end else begin
      r_wen <= (r_state == StWb);
      if (r_state == StRd && w_k == 2'd1) begin
        r_max <= w_din;
      end else if (r_state == StRd && w_k[1]) begin
        r_max <= w_max_fin;
      end
      if (r_state == StWb) begin
        r_waddr <= w_waddr;
        r_dout  <= w_pooled;
      end
    end
  end

  assign o_raddr    = w_raddr;
  assign o_ren      = (r_state == StRd);
  assign o_waddr    = r_waddr;
  assign o_wen      = r_wen;
  assign o_data_out = r_dout;
  assign o_busy     = (r_state != StIdle);

endmodule

// File: tb/tb_maxpool1.sv
// tb_maxpool1: scenario tasks for maxpool1 with a registered RAM model and a
// write scoreboard (expected pooled values queued at pass start, popped on wen).
module tb_maxpool1;

  localparam int NWIN = 3 * 12 * 12;
  localparam int NMEM = 3 * 24 * 24;

`ifdef MAXPOOL1_RELU_EN
  localparam logic [11:0] ExpNeg = 12'd0;
`else
  localparam logic [11:0] ExpNeg = 12'hFFE;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ub = 1'b0;
  logic [11:0] data_in = '0;
  logic [10:0] raddr;
  logic        ren;
  logic [8:0]  waddr;
  logic        wen;
  logic [11:0] data_out;
  logic        busy;

  typedef struct packed {
    logic [8:0]  addr;
    logic [11:0] data;
  } exp_t;

  exp_t               exp_q[$];
  exp_t               mon_e;
  logic signed [11:0] mem[NMEM];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  int wr_cnt = 0;
  int busy_cnt = 0;
  int last_raddr = -1;
  logic prev_wen = 1'b0;

  maxpool1 dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_upstream_busy (ub),
    .i_data_in       (data_in),
    .o_raddr         (raddr),
    .o_ren           (ren),
    .o_waddr         (waddr),
    .o_wen           (wen),
    .o_data_out      (data_out),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  // Conv1 RAM: registered read, data valid the cycle after ren.
  always @(posedge clk) begin
    if (ren) data_in <= mem[raddr];
  end

  // Write monitor / scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) busy_cnt++;
      if (ren) last_raddr = int'(raddr);
      if (wen) begin
        checks++;
        if (prev_wen) begin
          errors++;
          $display("FAIL wen_pulse: wen high on two consecutive cycles, required single pulse");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: write waddr=%0d data=%h, required no write", waddr, data_out);
        end else begin
          mon_e = exp_q.pop_front();
          wr_cnt++;
          if (waddr !== mon_e.addr || data_out !== mon_e.data) begin
            errors++;
            $display("FAIL sb_write: got waddr=%0d data=%h, required waddr=%0d data=%h",
                     waddr, data_out, mon_e.addr, mon_e.data);
          end
        end
      end
      prev_wen = wen;
    end
  end

  task automatic fill_mem();
    for (int a = 0; a < NMEM; a++) mem[a] = 12'((a % 97) - 48);
    mem[0]  = 12'sd5;
    mem[1]  = -12'sd3;
    mem[24] = 12'sd17;
    mem[25] = 12'sd2;
    mem[2]  = -12'sd8;
    mem[3]  = -12'sd2;
    mem[26] = -12'sd5;
    mem[27] = -12'sd100;
  endtask

  task automatic push_expected();
    logic signed [11:0] m;
    logic signed [11:0] v;
    int base;
    exp_q.delete();
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 12; r++)
        for (int c = 0; c < 12; c++) begin
          base = ch * 576 + 2 * r * 24 + 2 * c;
          m = mem[base];
          v = mem[base + 1];  if (v > m) m = v;
          v = mem[base + 24]; if (v > m) m = v;
          v = mem[base + 25]; if (v > m) m = v;
`ifdef MAXPOOL1_RELU_EN
          if (m < 0) m = '0;
`endif
          exp_q.push_back({9'(ch * 144 + r * 12 + c), m});
        end
  endtask

  task automatic start_pass();
    @(negedge clk) ub = 1'b1;
    @(negedge clk) ub = 1'b0;
  endtask

  task automatic test_reset();
    int hi;
    rst_n = 1'b0;
    ub    = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({raddr, ren, waddr, wen, data_out, busy} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required all zero",
               {raddr, ren, waddr, wen, data_out, busy});
    end
    rst_n = 1'b1;
    ub    = 1'b0;
    hi    = 0;
    repeat (10) begin
      @(negedge clk);
      if (ren || busy) hi++;
    end
    checks++;
    if (hi !== 0) begin
      errors++;
      $display("FAIL no_start: ren/busy high on %0d cycles, required 0", hi);
    end
  endtask

  task automatic test_first_window();
    logic [10:0] exp_ra[4] = '{11'd0, 11'd1, 11'd24, 11'd25};
    int n;
    fill_mem();
    push_expected();
    wr_cnt = 0; busy_cnt = 0; last_raddr = -1; prev_wen = 1'b0;
    mon_en = 1'b1;
    start_pass();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (ren !== 1'b1 || raddr !== exp_ra[k] || busy !== 1'b1) begin
        errors++;
        $display("FAIL read_seq%0d: got ren=%b raddr=%0d busy=%b, required ren=1 raddr=%0d busy=1",
                 k, ren, raddr, busy, exp_ra[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (ren !== 1'b0 || busy !== 1'b1 || wen !== 1'b0) begin
      errors++;
      $display("FAIL wb_cycle: got ren=%b busy=%b wen=%b, required 0 1 0", ren, busy, wen);
    end
    @(negedge clk);
    checks++;
    if (wen !== 1'b1 || waddr !== 9'd0 || data_out !== 12'd17) begin
      errors++;
      $display("FAIL first_write: got wen=%b waddr=%0d data=%h, required 1 0 011",
               wen, waddr, data_out);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (wen !== 1'b1 || waddr !== 9'd1 || data_out !== ExpNeg) begin
      errors++;
      $display("FAIL neg_window: got wen=%b waddr=%0d data=%h, required 1 1 %h",
               wen, waddr, data_out, ExpNeg);
    end
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
      // A falling edge mid-pass must be ignored.
      if (n == 100) ub = 1'b1;
      if (n == 103) ub = 1'b0;
    end
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL pass_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
    checks++;
    if (wr_cnt !== NWIN || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL write_count: got %0d writes (%0d pending), required %0d",
               wr_cnt, exp_q.size(), NWIN);
    end
    checks++;
    if (busy_cnt !== 2161) begin
      errors++;
      $display("FAIL busy_cycles: got %0d, required 2161", busy_cnt);
    end
    checks++;
    if (last_raddr !== 1727) begin
      errors++;
      $display("FAIL last_raddr: got %0d, required 1727", last_raddr);
    end
  endtask

  task automatic test_no_restart();
    int hi;
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (ren || busy || wen) hi++;
    end
    checks++;
    if (hi !== 0) begin
      errors++;
      $display("FAIL no_restart: activity on %0d cycles, required 0", hi);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    int hi;
    push_expected();
    wr_cnt = 0;
    start_pass();
    n = 0;
    while (wr_cnt < 50 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (wr_cnt < 50) begin
      errors++;
      $display("FAIL mid_wait: got %0d writes, required 50", wr_cnt);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({raddr, ren, waddr, wen, data_out, busy} !== 35'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h, required all zero",
               {raddr, ren, waddr, wen, data_out, busy});
    end
    rst_n = 1'b1;
    exp_q.delete();
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (ren || busy) hi++;
    end
    checks++;
    if (hi !== 0) begin
      errors++;
      $display("FAIL mid_reset_idle: activity on %0d cycles, required 0", hi);
    end
    push_expected();
    wr_cnt = 0; busy_cnt = 0;
    start_pass();
    @(negedge clk);
    checks++;
    if (ren !== 1'b1 || raddr !== 11'd0) begin
      errors++;
      $display("FAIL restart_raddr: got ren=%b raddr=%0d, required 1 0", ren, raddr);
    end
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    #1;
    checks++;
    if (busy !== 1'b0 || wr_cnt !== NWIN || exp_q.size() !== 0 || busy_cnt !== 2161) begin
      errors++;
      $display("FAIL restart_pass: got busy=%b writes=%0d pending=%0d busy_cycles=%0d, required 0 %0d 0 2161",
               busy, wr_cnt, exp_q.size(), busy_cnt, NWIN);
    end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_no_restart();
    test_mid_reset();
    test_no_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
